// File: rtl/svm_classifier_pkg.sv
// Shared types and constants for the linear-kernel SVM classifier.
// Imported by the interface, the MAC datapath and the top level.
package svm_classifier_pkg;

  localparam int XW       = 9;
  localparam int ACCW     = 32;
  localparam int N_SV_DEF = 16;
  localparam int CW       = 5;

  localparam logic [1:0] Y_POS = 2'b01;
  localparam logic [1:0] Y_NEG = 2'b11;

  typedef enum logic [1:0] {
    LOAD,
    READY,
    MAC,
    RESULT
  } state_t;

  typedef struct packed {
    logic [XW-1:0] x;
    logic [1:0]    y;
    logic [XW-1:0] alpha;
  } sv_entry_t;

endpackage

// File: rtl/svm_classifier_if.sv
// Support-vector stream, test-sample handshake and result bundle.
// The master side is the producer/consumer around the classifier.
interface svm_classifier_if;
  import svm_classifier_pkg::*;

  logic                   sv_clear;
  logic                   sv_valid;
  logic                   sv_last;
  logic [XW-1:0]          x_sv;
  logic [1:0]             y_sv;
  logic [XW-1:0]          alpha_sv;
  logic                   sv_done;
  logic [CW-1:0]          sv_count;
  logic                   sv_overflow;
  logic signed [ACCW-1:0] bias;
  logic [XW-1:0]          x_test;
  logic                   test_valid;
  logic                   test_ready;
  logic                   result_valid;
  logic [1:0]             y_out;
  logic signed [ACCW-1:0] score;

  modport master (
    output sv_clear, sv_valid, sv_last,
    output x_sv, y_sv, alpha_sv,
    output bias, x_test, test_valid,
    input  sv_done, sv_count, sv_overflow,
    input  test_ready, result_valid,
    input  y_out, score
  );

  modport slave (
    input  sv_clear, sv_valid, sv_last,
    input  x_sv, y_sv, alpha_sv,
    input  bias, x_test, test_valid,
    output sv_done, sv_count, sv_overflow,
    output test_ready, result_valid,
    output y_out, score
  );

endinterface

// File: rtl/svm_classifier_sv_mac.sv
// One multiply-accumulate step: acc +/- alpha*x*x_test by label.
// Labels 00 and 10 are not support classes and leave acc unchanged.
module svm_classifier_sv_mac
  import svm_classifier_pkg::*;
(
  input  sv_entry_t              ent,
  input  logic [XW-1:0]          xt,
  input  logic signed [ACCW-1:0] acc_in,
  output logic signed [ACCW-1:0] acc_out
);

  logic [3*XW-1:0]        term;
  logic signed [ACCW-1:0] term_s;

  always_comb begin
    term = (3*XW)'(ent.alpha)
         * (3*XW)'(ent.x)
         * (3*XW)'(xt);
    term_s = signed'(ACCW'(term));
    acc_out = acc_in;
    unique case (1'b1)
      ent.y == Y_POS: acc_out = acc_in + term_s;
      ent.y == Y_NEG: acc_out = acc_in - term_s;
      default:        acc_out = acc_in;
    endcase
  end

endmodule

// File: rtl/svm_classifier.sv
// SVM classifier top: support-vector buffer, control FSM and result regs.
// Sums one buffered entry per cycle into a score seeded with the bias.
module svm_classifier
  import svm_classifier_pkg::*;
#(
  parameter int N_SV = N_SV_DEF
) (
  input logic             clk,
  input logic             resetn,
  svm_classifier_if.slave bus
);

  localparam int AW = $clog2(N_SV);

  state_t                 state;
  sv_entry_t              sv_mem [N_SV];
  logic [CW-1:0]          wr_ptr;
  logic [CW-1:0]          idx;
  logic [XW-1:0]          xt;
  logic signed [ACCW-1:0] acc;
  logic signed [ACCW-1:0] acc_nxt;
  logic                   full;
  logic                   wr_en;

  assign full  = wr_ptr >= CW'(N_SV);
  assign wr_en = (state == LOAD) && !bus.sv_clear
              && bus.sv_valid && !full;
  assign bus.sv_count = wr_ptr;

  // Buffer storage needs no reset; wr_ptr alone defines what is valid.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      sv_mem[wr_ptr[AW-1:0]] <= '{
        x:     bus.x_sv,
        y:     bus.y_sv,
        alpha: bus.alpha_sv
      };
    end
  end

  svm_classifier_sv_mac u_mac (
    .ent    (sv_mem[idx[AW-1:0]]),
    .xt     (xt),
    .acc_in (acc),
    .acc_out(acc_nxt)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state            <= LOAD;
      wr_ptr           <= '0;
      idx              <= '0;
      xt               <= '0;
      acc              <= '0;
      bus.sv_done      <= 1'b0;
      bus.sv_overflow  <= 1'b0;
      bus.test_ready   <= 1'b0;
      bus.result_valid <= 1'b0;
      bus.y_out        <= '0;
      bus.score        <= '0;
    end else begin
      bus.result_valid <= 1'b0;
      if (bus.sv_clear) begin
        state           <= LOAD;
        wr_ptr          <= '0;
        bus.sv_done     <= 1'b0;
        bus.sv_overflow <= 1'b0;
        bus.test_ready  <= 1'b0;
      end else begin
        unique case (state)
          LOAD: begin
            if (bus.sv_valid) begin
              if (!full) wr_ptr <= wr_ptr + CW'(1);
              else       bus.sv_overflow <= 1'b1;
            end
            if (bus.sv_last) begin
              state          <= READY;
              bus.sv_done    <= 1'b1;
              bus.test_ready <= 1'b1;
            end
          end
          READY: begin
            if (bus.test_valid) begin
              xt             <= bus.x_test;
              acc            <= bus.bias;
              idx            <= '0;
              bus.test_ready <= 1'b0;
              state <= (wr_ptr == '0) ? RESULT : MAC;
            end
          end
          MAC: begin
            acc <= acc_nxt;
            idx <= idx + CW'(1);
            if (idx == wr_ptr - CW'(1)) state <= RESULT;
          end
          RESULT: begin
            bus.result_valid <= 1'b1;
            bus.score        <= acc;
            bus.y_out        <= acc[ACCW-1] ? Y_NEG : Y_POS;
            bus.test_ready   <= 1'b1;
            state            <= READY;
          end
          default: state <= LOAD;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_svm_classifier.sv
// Directed bench for svm_classifier with a score/latency reference model.
// A second instance with a 4-entry buffer covers overflow behaviour.
module tb_svm_classifier;
  import svm_classifier_pkg::*;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  svm_classifier_if b ();
  svm_classifier_if s ();

  svm_classifier #(.N_SV(16)) dut (
    .clk   (clk),
    .resetn(resetn),
    .bus   (b.slave)
  );

  svm_classifier #(.N_SV(4)) dut_s (
    .clk   (clk),
    .resetn(resetn),
    .bus   (s.slave)
  );

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // reference model: entries loaded into the 16-deep instance
  int mx [16];
  int my [16];
  int ma [16];
  int mcnt = 0;

  bit                   exp_pend = 0;
  int                   exp_due  = 0;
  logic signed [31:0]   exp_sc   = '0;
  logic [1:0]           exp_y    = '0;

  task automatic chk(string nm, longint act, longint exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic step(int n = 1);
    repeat (n) @(negedge clk);
  endtask

  // per-cycle comparison of the result channel against the model
  always @(negedge clk) begin
    bit due;
    if (resetn) begin
      due = exp_pend && (cyc == exp_due);
      chk("result_valid", longint'(b.result_valid),
          longint'(due));
      if (due) begin
        chk("score", longint'($signed(b.score)),
            longint'(exp_sc));
        chk("y_out", longint'(b.y_out), longint'(exp_y));
        exp_pend = 0;
      end
    end
  end

  task automatic ld(int x, int y, int a, bit lst = 0);
    b.sv_valid = 1'b1;
    b.sv_last  = lst;
    b.x_sv     = XW'(x);
    b.y_sv     = 2'(y);
    b.alpha_sv = XW'(a);
    step();
    b.sv_valid = 1'b0;
    b.sv_last  = 1'b0;
    if (mcnt < 16) begin
      mx[mcnt] = x;
      my[mcnt] = y;
      ma[mcnt] = a;
      mcnt++;
    end
  endtask

  task automatic fin();
    b.sv_last = 1'b1;
    step();
    b.sv_last = 1'b0;
  endtask

  task automatic clr();
    b.sv_clear = 1'b1;
    step();
    b.sv_clear = 1'b0;
    mcnt = 0;
  endtask

  task automatic classify(int xt, int bias);
    longint sum;
    int k;
    k = 0;
    while (!b.test_ready && k < 50) begin
      step();
      k++;
    end
    if (!b.test_ready) begin
      n_chk++;
      n_fail++;
      $display("FAIL test_ready_wait: got 0 expected 1");
      return;
    end
    sum = bias;
    for (int i = 0; i < mcnt; i++) begin
      if (my[i] == 1)
        sum += longint'(ma[i]) * mx[i] * xt;
      else if (my[i] == 3)
        sum -= longint'(ma[i]) * mx[i] * xt;
    end
    exp_sc   = 32'(sum);
    exp_y    = (exp_sc >= 0) ? 2'b01 : 2'b11;
    exp_due  = cyc + mcnt + 2;
    exp_pend = 1;
    b.test_valid = 1'b1;
    b.x_test     = XW'(xt);
    b.bias       = 32'(bias);
    step();
    b.test_valid = 1'b0;
    k = 0;
    while (exp_pend && k < 60) begin
      step();
      k++;
    end
    if (exp_pend) begin
      n_chk++;
      n_fail++;
      $display("FAIL result_timeout: got none expected pulse");
      exp_pend = 0;
    end
  endtask

  initial begin
    b.sv_clear = 0; b.sv_valid = 0; b.sv_last = 0;
    b.x_sv = '0; b.y_sv = '0; b.alpha_sv = '0;
    b.bias = '0; b.x_test = '0; b.test_valid = 0;
    s.sv_clear = 0; s.sv_valid = 0; s.sv_last = 0;
    s.x_sv = '0; s.y_sv = '0; s.alpha_sv = '0;
    s.bias = '0; s.x_test = '0; s.test_valid = 0;

    step(2);
    chk("rst_sv_done", longint'(b.sv_done), 0);
    chk("rst_sv_count", longint'(b.sv_count), 0);
    chk("rst_overflow", longint'(b.sv_overflow), 0);
    chk("rst_test_ready", longint'(b.test_ready), 0);
    chk("rst_result_valid", longint'(b.result_valid), 0);
    chk("rst_y_out", longint'(b.y_out), 0);
    chk("rst_score", longint'(b.score), 0);
    resetn = 1'b1;
    step();

    // 4-deep buffer: six writes, two dropped
    for (int i = 0; i < 6; i++) begin
      s.sv_valid = 1'b1;
      s.x_sv     = XW'(i + 1);
      s.y_sv     = 2'b01;
      s.alpha_sv = XW'(1);
      step();
    end
    s.sv_valid = 1'b0;
    s.sv_last  = 1'b1;
    step();
    s.sv_last  = 1'b0;
    chk("small_count", longint'(s.sv_count), 4);
    chk("small_overflow", longint'(s.sv_overflow), 1);
    chk("small_done", longint'(s.sv_done), 1);

    // two SVs, positive result
    ld(3, 1, 2);
    ld(5, 3, 1);
    fin();
    chk("t1_done", longint'(b.sv_done), 1);
    chk("t1_count", longint'(b.sv_count), 2);
    chk("t1_overflow", longint'(b.sv_overflow), 0);
    classify(4, 0);
    chk("t1_score_lit", longint'($signed(b.score)), 4);
    chk("t1_y_lit", longint'(b.y_out), 1);

    // bias only, negative
    classify(0, -1);
    chk("t2_score_lit", longint'($signed(b.score)), -1);
    chk("t2_y_lit", longint'(b.y_out), 3);

    // empty buffer
    clr();
    chk("clr_done", longint'(b.sv_done), 0);
    fin();
    chk("t4_count", longint'(b.sv_count), 0);
    classify(9, 7);
    chk("t4_score_lit", longint'($signed(b.score)), 7);
    chk("t4_y_lit", longint'(b.y_out), 1);

    // full buffer, worst-case magnitude, last entry with sv_last
    clr();
    for (int i = 0; i < 15; i++) ld(511, 1, 511);
    ld(511, 1, 511, 1'b1);
    chk("t5_count", longint'(b.sv_count), 16);
    chk("t5_done", longint'(b.sv_done), 1);
    classify(511, 0);
    chk("t5_score_lit", longint'($signed(b.score)),
        64'd2134925296);
    chk("t5_y_lit", longint'(b.y_out), 1);

    // reset while MAC is running
    clr();
    ld(3, 1, 2);
    ld(5, 3, 1);
    ld(7, 1, 7);
    ld(2, 1, 2);
    fin();
    b.test_valid = 1'b1;
    b.x_test     = XW'(4);
    b.bias       = '0;
    step();
    b.test_valid = 1'b0;
    step();
    resetn = 1'b0;
    mcnt   = 0;
    step();
    chk("t6_rv_in_rst", longint'(b.result_valid), 0);
    resetn = 1'b1;
    step(6);
    chk("t6_done", longint'(b.sv_done), 0);
    chk("t6_count", longint'(b.sv_count), 0);
    chk("t6_ready", longint'(b.test_ready), 0);
    chk("t6_small_ovf", longint'(s.sv_overflow), 0);

    // sv_clear from READY, then reload with a non-class label
    ld(1, 1, 1);
    fin();
    chk("t6_ready_up", longint'(b.test_ready), 1);
    clr();
    chk("t6_clr_ready", longint'(b.test_ready), 0);
    chk("t6_clr_done", longint'(b.sv_done), 0);
    chk("t6_clr_count", longint'(b.sv_count), 0);
    ld(3, 1, 2);
    ld(5, 3, 1);
    ld(100, 0, 100);
    ld(2, 1, 3);
    fin();
    classify(4, 0);
    chk("t6_score_lit", longint'($signed(b.score)), 28);
    chk("t6_y_lit", longint'(b.y_out), 1);
    classify(1, -40);
    chk("t6_neg_lit", longint'($signed(b.score)), -33);
    chk("t6_neg_y_lit", longint'(b.y_out), 3);

    step(3);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got hang expected finish");
    $fatal(1);
  end

endmodule
